// File: rtl/cevero_ft_pkg.sv
// rtl/cevero_ft_pkg.sv - shared types and defaults for the CEVERO lockstep wrapper
// Recovery FSM states, the per-cycle compare vector and its idle-data masking.
package cevero_ft_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    RESET  = 2'd2,
    FAILED = 2'd3
  } ft_state_e;

  typedef struct packed {
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
  } cmp_vec_t;

  localparam int unsigned RST_CYCLES_DEFAULT  = 4;
  localparam int unsigned MAX_RETRIES_DEFAULT = 3;

  // Store attributes are don't-care while no data request is presented.
  function automatic cmp_vec_t mask_idle_data(input cmp_vec_t v);
    cmp_vec_t m;
    m = v;
    if (!v.data_req) begin
      m.data_we    = 1'b0;
      m.data_be    = '0;
      m.data_wdata = '0;
    end
    return m;
  endfunction

endpackage

// File: rtl/cevero_ft_checker.sv
// rtl/cevero_ft_checker.sv - per-cycle comparator of the two cores' bus vectors
// With FT_ERROR_INJECT_EN, force_error_i flips bit 0 of core_1's addresses once.
module cevero_ft_checker
  import cevero_ft_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     run_i,
  input  logic     force_error_i,
  input  cmp_vec_t vec_0_i,
  input  cmp_vec_t vec_1_i,
  output logic     mismatch_o
);
  cmp_vec_t v0, v1;

`ifdef FT_ERROR_INJECT_EN
  logic can_inject_error_q, can_inject_error_d;
  logic inject;

  assign inject = can_inject_error_q & force_error_i;
  // The flag is only spent when the corrupted vector is actually compared.
  assign can_inject_error_d = can_inject_error_q & ~(inject & run_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) can_inject_error_q <= 1'b1;
    else       can_inject_error_q <= can_inject_error_d;
  end

  always_comb begin
    v0 = mask_idle_data(vec_0_i);
    v1 = mask_idle_data(vec_1_i);
    if (inject) begin
      v1.instr_addr[0] = ~v1.instr_addr[0];
      v1.data_addr[0]  = ~v1.data_addr[0];
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{clk_i, rst_i, force_error_i};

  always_comb begin
    v0 = mask_idle_data(vec_0_i);
    v1 = mask_idle_data(vec_1_i);
  end
`endif

  assign mismatch_o = run_i & (v0 != v1);
endmodule

// File: rtl/ibex_core.sv
// rtl/ibex_core.sv - minimal behavioural stand-in with the ibex_core bus interface
// Tiny accumulator ISA: 1 LOADI, 2 MULI, 3 STORE, 4 LOAD, F HALT, others NOP.
module ibex_core (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        test_en_i,
  input  logic [31:0] hart_id_i,
  input  logic [31:0] boot_addr_i,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  input  logic        irq_software_i,
  input  logic        irq_timer_i,
  input  logic        irq_external_i,
  input  logic [14:0] irq_fast_i,
  input  logic        irq_nm_i,
  input  logic        debug_req_i,
  input  logic        fetch_enable_i,
  output logic        core_sleep_o
);
  localparam logic [2:0] C_FETCH  = 3'd0;
  localparam logic [2:0] C_WAIT_I = 3'd1;
  localparam logic [2:0] C_DREQ   = 3'd2;
  localparam logic [2:0] C_WAIT_D = 3'd3;
  localparam logic [2:0] C_HALT   = 3'd4;

  logic [2:0]  st_q, st_d;
  logic [31:0] pc_q, pc_d, acc_q, acc_d, ir_q, ir_d;
  logic [3:0]  new_op;
  logic        unused_inputs;

  assign new_op = instr_rdata_i[31:28];
  assign unused_inputs = ^{test_en_i, hart_id_i, data_err_i, irq_software_i, irq_timer_i,
                           irq_external_i, irq_fast_i, irq_nm_i, debug_req_i, ir_q[27:16]};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_q  <= C_FETCH;
      pc_q  <= boot_addr_i;
      acc_q <= '0;
      ir_q  <= '0;
    end else begin
      st_q  <= st_d;
      pc_q  <= pc_d;
      acc_q <= acc_d;
      ir_q  <= ir_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    pc_d  = pc_q;
    acc_d = acc_q;
    ir_d  = ir_q;
    case (st_q)
      C_FETCH: if (fetch_enable_i && instr_gnt_i) st_d = C_WAIT_I;
      C_WAIT_I: begin
        if (instr_rvalid_i) begin
          ir_d = instr_rdata_i;
          if (instr_err_i || new_op == 4'hf) begin
            st_d = C_HALT;
          end else if (new_op == 4'h3 || new_op == 4'h4) begin
            st_d = C_DREQ;
          end else begin
            st_d = C_FETCH;
            pc_d = pc_q + 32'd4;
            if (new_op == 4'h1) acc_d = {16'h0, instr_rdata_i[15:0]};
            else if (new_op == 4'h2) acc_d = acc_q * {16'h0, instr_rdata_i[15:0]};
          end
        end
      end
      C_DREQ: if (data_gnt_i) st_d = C_WAIT_D;
      C_WAIT_D: begin
        if (data_rvalid_i) begin
          st_d = C_FETCH;
          pc_d = pc_q + 32'd4;
          if (ir_q[31:28] == 4'h4) acc_d = data_rdata_i;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    instr_req_o  = (st_q == C_FETCH) && fetch_enable_i;
    instr_addr_o = pc_q;
    data_req_o   = (st_q == C_DREQ);
    data_we_o    = (ir_q[31:28] == 4'h3);
    data_be_o    = 4'hf;
    data_addr_o  = {16'h0, ir_q[15:0]};
    data_wdata_o = acc_q;
    core_sleep_o = (st_q == C_HALT);
  end
endmodule

// File: rtl/cevero_ft_lockstep.sv
// rtl/cevero_ft_lockstep.sv - dual-core lockstep wrapper with drain/reset/retry recovery
// Optional fault injection through FT_ERROR_INJECT_EN (see cevero_ft_checker).
module cevero_ft_lockstep
  import cevero_ft_pkg::*;
#(
  parameter int unsigned RST_CYCLES  = RST_CYCLES_DEFAULT,
  parameter int unsigned MAX_RETRIES = MAX_RETRIES_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        test_en_i,
  input  logic        force_error_i,
  input  logic [31:0] hart_id_i,
  input  logic [31:0] boot_addr_i,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  input  logic        irq_software_i,
  input  logic        irq_timer_i,
  input  logic        irq_external_i,
  input  logic        irq_nm_i,
  input  logic [14:0] irq_fast_i,
  input  logic        debug_req_i,
  input  logic        fetch_enable_i,
  output logic        alert_minor_o,
  output logic        alert_major_o,
  output logic        core_sleep_o,
  output logic [31:0] instr_addr_o_0
);
  ft_state_e   state_q, state_d;
  logic [7:0]  retry_q, retry_d, rst_cnt_q, rst_cnt_d;
  logic        core_rst_q, core_rst_d;
  logic        alert_minor_q, alert_minor_d;
  logic        i_out_q, i_out_d, d_out_q, d_out_d;
  logic        chk_mismatch, mismatch, run_ok;
  logic        core_rst_n, core_instr_gnt, core_data_gnt;

  logic        c0_instr_req, c0_data_req, c0_data_we, c0_sleep;
  logic        c1_instr_req, c1_data_req, c1_data_we, c1_sleep;
  logic [3:0]  c0_data_be, c1_data_be;
  logic [31:0] c0_instr_addr, c0_data_addr, c0_data_wdata;
  logic [31:0] c1_instr_addr, c1_data_addr, c1_data_wdata;
  cmp_vec_t    vec_0, vec_1;

  assign core_rst_n = ~core_rst_q;
  // A grant only means something to the cores when the wrapper let the request out.
  assign core_instr_gnt = instr_gnt_i & instr_req_o;
  assign core_data_gnt  = data_gnt_i & data_req_o;

  ibex_core u_core_0 (
    .clk_i, .rst_ni(core_rst_n), .test_en_i, .hart_id_i, .boot_addr_i,
    .instr_req_o(c0_instr_req), .instr_gnt_i(core_instr_gnt), .instr_rvalid_i,
    .instr_addr_o(c0_instr_addr), .instr_rdata_i, .instr_err_i,
    .data_req_o(c0_data_req), .data_gnt_i(core_data_gnt), .data_rvalid_i,
    .data_we_o(c0_data_we), .data_be_o(c0_data_be), .data_addr_o(c0_data_addr),
    .data_wdata_o(c0_data_wdata), .data_rdata_i, .data_err_i,
    .irq_software_i, .irq_timer_i, .irq_external_i, .irq_fast_i, .irq_nm_i,
    .debug_req_i, .fetch_enable_i, .core_sleep_o(c0_sleep)
  );

  ibex_core u_core_1 (
    .clk_i, .rst_ni(core_rst_n), .test_en_i, .hart_id_i, .boot_addr_i,
    .instr_req_o(c1_instr_req), .instr_gnt_i(core_instr_gnt), .instr_rvalid_i,
    .instr_addr_o(c1_instr_addr), .instr_rdata_i, .instr_err_i,
    .data_req_o(c1_data_req), .data_gnt_i(core_data_gnt), .data_rvalid_i,
    .data_we_o(c1_data_we), .data_be_o(c1_data_be), .data_addr_o(c1_data_addr),
    .data_wdata_o(c1_data_wdata), .data_rdata_i, .data_err_i,
    .irq_software_i, .irq_timer_i, .irq_external_i, .irq_fast_i, .irq_nm_i,
    .debug_req_i, .fetch_enable_i, .core_sleep_o(c1_sleep)
  );

  assign vec_0 = '{c0_instr_req, c0_instr_addr, c0_data_req, c0_data_we,
                   c0_data_be, c0_data_addr, c0_data_wdata};
  assign vec_1 = '{c1_instr_req, c1_instr_addr, c1_data_req, c1_data_we,
                   c1_data_be, c1_data_addr, c1_data_wdata};

  cevero_ft_checker u_checker (
    .clk_i,
    .rst_i,
    .run_i        (state_q == RUN),
    .force_error_i,
    .vec_0_i      (vec_0),
    .vec_1_i      (vec_1),
    .mismatch_o   (chk_mismatch)
  );

  assign mismatch = chk_mismatch & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= RUN;
      retry_q       <= '0;
      rst_cnt_q     <= '0;
      alert_minor_q <= 1'b0;
      i_out_q       <= 1'b0;
      d_out_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      retry_q       <= retry_d;
      rst_cnt_q     <= rst_cnt_d;
      alert_minor_q <= alert_minor_d;
      i_out_q       <= i_out_d;
      d_out_q       <= d_out_d;
    end
    core_rst_q <= core_rst_d;
  end

  always_comb begin
    state_d       = state_q;
    retry_d       = retry_q;
    rst_cnt_d     = '0;
    alert_minor_d = 1'b0;
    i_out_d       = (i_out_q & ~instr_rvalid_i) | (instr_req_o & instr_gnt_i);
    d_out_d       = (d_out_q & ~data_rvalid_i) | (data_req_o & data_gnt_i);
    case (state_q)
      RUN: begin
        if (mismatch) begin
          if (retry_q == 8'(MAX_RETRIES)) begin
            state_d = FAILED;
          end else begin
            state_d       = DRAIN;
            retry_d       = retry_q + 8'd1;
            alert_minor_d = 1'b1;
          end
        end
      end
      DRAIN: if (!i_out_q && !d_out_q) state_d = RESET;
      RESET: begin
        if (rst_cnt_q == 8'(RST_CYCLES - 1)) state_d = RUN;
        else rst_cnt_d = rst_cnt_q + 8'd1;
      end
      default: state_d = FAILED;
    endcase
    core_rst_d = rst_i | (state_d == RESET) | (state_d == FAILED);
  end

  always_comb begin
    run_ok         = ~rst_i & (state_q == RUN) & ~mismatch;
    instr_req_o    = run_ok & c0_instr_req;
    data_req_o     = run_ok & c0_data_req;
    instr_addr_o   = rst_i ? '0 : c0_instr_addr;
    data_we_o      = ~rst_i & c0_data_we;
    data_be_o      = rst_i ? '0 : c0_data_be;
    data_addr_o    = rst_i ? '0 : c0_data_addr;
    data_wdata_o   = rst_i ? '0 : c0_data_wdata;
    alert_minor_o  = alert_minor_q;
    alert_major_o  = ~rst_i & (state_q == FAILED);
    core_sleep_o   = ~rst_i & c0_sleep & c1_sleep;
    instr_addr_o_0 = c0_instr_addr;
  end
endmodule

// File: tb/tb_cevero_ft_lockstep.sv
// tb/tb_cevero_ft_lockstep.sv - directed bench for the lockstep wrapper
// Runs a factorial program from a bench memory model; FT_ERROR_INJECT_EN selects injection checks.
module tb_cevero_ft_lockstep;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        test_en_i = 1'b0, force_error_i = 1'b0;
  logic [31:0] hart_id_i = '0, boot_addr_i = '0;
  logic        instr_req_o, instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0, instr_err_i = 1'b0;
  logic [31:0] instr_addr_o, instr_rdata_i = '0, instr_addr_o_0;
  logic        data_req_o, data_gnt_i = 1'b0, data_rvalid_i = 1'b0, data_we_o, data_err_i = 1'b0;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i = '0;
  logic        irq_software_i = 1'b0, irq_timer_i = 1'b0, irq_external_i = 1'b0, irq_nm_i = 1'b0;
  logic [14:0] irq_fast_i = '0;
  logic        debug_req_i = 1'b0, fetch_enable_i = 1'b0;
  logic        alert_minor_o, alert_major_o, core_sleep_o;

`ifdef FT_ERROR_INJECT_EN
  localparam int INJ_ALERTS = 1;
`else
  localparam int INJ_ALERTS = 0;
`endif

  cevero_ft_lockstep dut (
    .clk_i(clk), .rst_i(rst_i), .test_en_i(test_en_i), .force_error_i(force_error_i),
    .hart_id_i(hart_id_i), .boot_addr_i(boot_addr_i),
    .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
    .instr_addr_o(instr_addr_o), .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_addr_o(data_addr_o),
    .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
    .irq_software_i(irq_software_i), .irq_timer_i(irq_timer_i), .irq_external_i(irq_external_i),
    .irq_nm_i(irq_nm_i), .irq_fast_i(irq_fast_i), .debug_req_i(debug_req_i),
    .fetch_enable_i(fetch_enable_i), .alert_minor_o(alert_minor_o),
    .alert_major_o(alert_major_o), .core_sleep_o(core_sleep_o), .instr_addr_o_0(instr_addr_o_0)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:15];
  logic        i_pend = 1'b0, d_pend = 1'b0, gnt_delay_en = 1'b0, hold_drvalid = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0;
  int          i_dly = 0, d_dly = 0;
  int          n_checks = 0, n_fail = 0, minor_total = 0, base = 0;

  // sp_ram-like responder: grant on the falling edge, rvalid one cycle later.
  always @(negedge clk) begin
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
    if (i_pend) begin
      instr_rvalid_i = 1'b1; instr_rdata_i = imem[i_addr[7:2]]; i_pend = 1'b0;
    end
    if (instr_req_o) begin
      if (i_dly == 0) begin
        instr_gnt_i = 1'b1; i_pend = 1'b1; i_addr = instr_addr_o;
        i_dly = gnt_delay_en ? int'($urandom_range(0, 3)) : 0;
      end else i_dly--;
    end
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    if (d_pend && !hold_drvalid) begin
      data_rvalid_i = 1'b1; data_rdata_i = dmem[d_addr[5:2]]; d_pend = 1'b0;
    end
    if (data_req_o) begin
      if (d_dly == 0) begin
        data_gnt_i = 1'b1; d_pend = 1'b1; d_addr = data_addr_o;
        if (data_we_o)
          for (int b = 0; b < 4; b++)
            if (data_be_o[b]) dmem[data_addr_o[5:2]][8*b +: 8] = data_wdata_o[8*b +: 8];
        d_dly = gnt_delay_en ? int'($urandom_range(0, 3)) : 0;
      end else d_dly--;
    end
    if (alert_minor_o) minor_total++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic start_run(input logic fe);
    for (int i = 0; i < 16; i++) dmem[i] = '0;
    @(posedge clk); #1;
    rst_i = 1'b1; fetch_enable_i = fe; i_dly = 0; d_dly = 0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    base = minor_total;
  endtask

  task automatic finish_run(input string tag, input int exp_minor);
    int n = 0;
    while (!core_sleep_o && n < 1000) begin sample(); n++; end
    check({tag, "_halt"}, core_sleep_o, 1);
    check({tag, "_word0"}, dmem[0], 32'd1);
    check({tag, "_word1"}, dmem[1], 32'd3628800);
    check({tag, "_word2"}, dmem[2], 32'd1);
    check({tag, "_minor"}, minor_total - base, exp_minor);
    check({tag, "_major"}, alert_major_o, 0);
    check({tag, "_req_idle"}, {instr_req_o, data_req_o}, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) imem[i] = '0;
    imem[0] = 32'h1000_0001;
    imem[1] = 32'h3000_0000;
    for (int k = 2; k <= 10; k++) imem[k] = 32'h2000_0000 | k;
    imem[11] = 32'h3000_0004;
    imem[12] = 32'h4000_0000;
    imem[13] = 32'h3000_0008;
    imem[14] = 32'hF000_0000;

    sample();
    check("rst_reqs", {instr_req_o, data_req_o}, 0);
    check("rst_alerts_sleep", {alert_minor_o, alert_major_o, core_sleep_o}, 0);
    check("rst_addrs", instr_addr_o | data_addr_o | data_wdata_o, 0);

    // fetch disabled: no fetch traffic, no alerts; then enabling runs the program
    start_run(1'b0);
    n = 0;
    repeat (30) begin sample(); if (instr_req_o) n++; end
    check("fe0_no_req", n, 0);
    check("fe0_no_alert", {alert_minor_o, alert_major_o}, 0);
    fetch_enable_i = 1'b1;
    finish_run("plain", 0);

    gnt_delay_en = 1'b1;
    start_run(1'b1);
    finish_run("delayed_gnt", 0);
    gnt_delay_en = 1'b0;

    // one-shot divergence on core_1's fetch address while core_0 is requesting
    start_run(1'b1);
    n = 0;
    while (n < 5) begin sample(); if (instr_rvalid_i) n++; end
    @(posedge clk); #1 force dut.c1_instr_addr = 32'hdead_beef;
    sample();
    check("mm_cycle_req", {instr_req_o, data_req_o}, 0);
    @(posedge clk); #1 release dut.c1_instr_addr;
    sample();
    check("mm_alert_pulse", alert_minor_o, 1);
    n = 0;
    while (!instr_req_o && n < 100) begin sample(); n++; end
    check("restart_req", instr_req_o, 1);
    check("restart_addr", instr_addr_o, 32'h0);
    finish_run("oneshot", 1);

    // force_error_i pulse: recovered once with injection, ignored otherwise
    start_run(1'b1);
    #220 force_error_i = 1'b1;
    #15 force_error_i = 1'b0;
    finish_run("inject_pulse", INJ_ALERTS);

    // persistent divergence: three recoveries, then permanent failure
    start_run(1'b1);
    repeat (3) sample();
    force dut.c1_instr_addr = 32'hdead_beef;
    n = 0;
    while (!alert_major_o && n < 300) begin sample(); n++; end
    check("failed_major", alert_major_o, 1);
    check("failed_minor_cnt", minor_total - base, 3);
    repeat (4) begin
      sample();
      check("failed_sticky", {alert_major_o, instr_req_o, data_req_o}, 3'b100);
    end
    release dut.c1_instr_addr;
    repeat (3) sample();
    check("failed_absorbing", alert_major_o, 1);
    @(posedge clk); #1 rst_i = 1'b1;
    sample();
    check("failed_cleared_by_rst", alert_major_o, 0);

`ifdef FT_ERROR_INJECT_EN
    start_run(1'b1);
    force dut.u_checker.can_inject_error_q = 1'b1;
    force_error_i = 1'b1;
    n = 0;
    while (!alert_major_o && n < 300) begin sample(); n++; end
    check("inj_failed_major", alert_major_o, 1);
    check("inj_failed_minor", minor_total - base, 3);
    sample();
    check("inj_failed_reqs", {instr_req_o, data_req_o}, 0);
    force_error_i = 1'b0;
    release dut.u_checker.can_inject_error_q;
`endif

    // reset during DRAIN with a data response still owed
    start_run(1'b1);
    n = 0;
    while (!data_gnt_i && n < 200) begin sample(); n++; end
    check("drain_got_dgnt", data_gnt_i, 1);
    @(posedge clk); #1;
    hold_drvalid = 1'b1;
    force dut.c1_instr_addr = 32'hdead_beef;
    sample();
    check("drain_mm_req", {instr_req_o, data_req_o}, 0);
    @(posedge clk); #1 release dut.c1_instr_addr;
    repeat (3) begin
      sample();
      check("drain_hold_req", {instr_req_o, data_req_o, alert_major_o}, 0);
    end
    @(posedge clk); #1 rst_i = 1'b1;
    repeat (2) begin
      sample();
      check("drain_rst_outs", {instr_req_o, data_req_o, alert_minor_o, alert_major_o, core_sleep_o}, 0);
      check("drain_rst_addrs", instr_addr_o | data_addr_o, 0);
      @(posedge clk); #1;
    end
    rst_i = 1'b0; hold_drvalid = 1'b0;
    base = minor_total;
    finish_run("drain_rst", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
